// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter.
//   MAX_REQ   : largest supported requester count
//   IDX_W     : width of a requester index
//   mem_req_t : one memory access (addr, wdata, wstrb)
//   rr_pick   : round-robin one-hot pick starting at ptr, over n requesters
package dmem_arb_pkg;

  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned AW      = 32;
  localparam int unsigned DW      = 32;
  localparam int unsigned SW      = 4;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
  } mem_req_t;

  // First valid requester at or above ptr, wrapping modulo n.
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0] valid,
    input logic [IDX_W-1:0]   ptr,
    input int unsigned        n
  );
    logic [MAX_REQ-1:0] gnt;
    logic [IDX_W-1:0]   idx;
    gnt = '0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      idx = IDX_W'((32'(ptr) + k) % n);
      if ((k < n) && (gnt == '0) && valid[idx]) gnt[idx] = 1'b1;
    end
    return gnt;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arbiter.sv
// Round-robin arbiter with grant locking.
//   clk, rst_n : clock, async active-low reset
//   valid      : per-requester request
//   lock       : per-requester "keep grant after this access"
//   grant_c    : one-hot grant (combinational); a grant is always an acceptance
module rr_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] valid,
  input  logic [N_REQ-1:0] lock,
  output logic [N_REQ-1:0] grant_c
);

  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   owner;
  logic               locked;
  logic [IDX_W-1:0]   gidx;
  logic [MAX_REQ-1:0] valid_ext;
  logic [MAX_REQ-1:0] lock_ext;
  logic [MAX_REQ-1:0] grant_ext;

  // Grant selection: locked owner wins while it keeps requesting.
  always_comb begin
    valid_ext = MAX_REQ'(valid);
    lock_ext  = MAX_REQ'(lock);
    grant_ext = '0;
    if (locked && valid_ext[owner]) grant_ext[owner] = 1'b1;
    else                            grant_ext = rr_pick(valid_ext, rr_ptr, N_REQ);
    gidx = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++)
      if (grant_ext[i]) gidx = IDX_W'(i);
  end

  assign grant_c = grant_ext[N_REQ-1:0];

  // Pointer/lock state: advance past the winner; owner dropping valid unlocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      owner  <= '0;
      locked <= 1'b0;
    end else if (|grant_ext) begin
      rr_ptr <= (32'(gidx) == N_REQ - 1) ? '0 : IDX_W'(gidx + 1'b1);
      owner  <= gidx;
      locked <= lock_ext[gidx];
    end else if (locked && !valid_ext[owner]) begin
      locked <= 1'b0;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-ported data memory between N_REQ requesters.
//   clk, rst_n         : clock, async active-low reset
//   req_valid/req_lock : per-requester request and grant-lock
//   req_addr/wdata/wstrb : packed per-requester access (wstrb 0 = read)
//   req_ready          : one-hot grant, same cycle as request
//   rsp_valid/rsp_rdata: registered one-cycle response per requester
//   d_addr/d_wdata/d_wstrb : memory port, zero when nothing is granted
//   d_rdata            : combinational read data from memory
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ-1:0]    req_lock,
  input  logic [N_REQ*32-1:0] req_addr,
  input  logic [N_REQ*32-1:0] req_wdata,
  input  logic [N_REQ*4-1:0]  req_wstrb,
  output logic [N_REQ-1:0]    req_ready,
  output logic [N_REQ-1:0]    rsp_valid,
  output logic [N_REQ*32-1:0] rsp_rdata,
  output logic [31:0]         d_addr,
  output logic [31:0]         d_wdata,
  output logic [3:0]          d_wstrb,
  input  logic [31:0]         d_rdata
);

  logic [N_REQ-1:0] grant_c;
  mem_req_t         sel_c;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (req_valid),
    .lock    (req_lock),
    .grant_c (grant_c)
  );

  // Memory mux: granted requester drives the port, otherwise all zero.
  always_comb begin
    sel_c = '0;
    for (int unsigned i = 0; i < N_REQ; i++)
      if (grant_c[i])
        sel_c = '{addr:  req_addr[32*i +: 32],
                  wdata: req_wdata[32*i +: 32],
                  wstrb: req_wstrb[4*i +: 4]};
  end

  assign req_ready = grant_c;
  assign d_addr    = sel_c.addr;
  assign d_wdata   = sel_c.wdata;
  assign d_wstrb   = sel_c.wstrb;

  // Response registers: pulse valid, capture read data (0 for write acks).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= grant_c;
      for (int unsigned i = 0; i < N_REQ; i++)
        if (grant_c[i])
          rsp_rdata[32*i +: 32] <= (sel_c.wstrb == '0) ? d_rdata : 32'h0;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: memory fixture, reference model with scoreboard
// queue, separate response monitor, directed scenarios then random traffic.
module tb_dmem_arbiter;

  localparam int unsigned N  = 2;
  localparam int unsigned MW = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_lock, req_ready, rsp_valid;
  logic [N*32-1:0] req_addr, req_wdata, rsp_rdata;
  logic [N*4-1:0]  req_wstrb;
  logic [31:0]     d_addr, d_wdata, d_rdata;
  logic [3:0]      d_wstrb;

  always #5 clk = ~clk;

  dmem_arbiter #(.N_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_lock(req_lock), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_rdata(d_rdata)
  );

  // Per-requester stimulus
  logic        v[N];
  logic        lk[N];
  logic [31:0] a[N];
  logic [31:0] wd[N];
  logic [3:0]  ws[N];

  always_comb begin
    req_valid = '0; req_lock = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    for (int i = 0; i < N; i++) begin
      req_valid[i]        = v[i];
      req_lock[i]         = lk[i];
      req_addr[32*i +: 32] = a[i];
      req_wdata[32*i +: 32] = wd[i];
      req_wstrb[4*i +: 4]  = ws[i];
    end
  end

  function automatic logic [31:0] init_word(int i);
    return {8'(i), 8'(~i), 8'(i * 3), 8'(i + 7)};
  endfunction

  // Memory fixture: combinational read, byte-strobed write on the edge
  logic [31:0] mem[MW];
  bit          fx_init;
  assign d_rdata = mem[d_addr[7:2]];

  always @(posedge clk) begin
    if (!fx_init) begin
      for (int i = 0; i < MW; i++) mem[i] <= init_word(i);
      fx_init <= 1'b1;
    end else begin
      for (int b = 0; b < 4; b++)
        if (d_wstrb[b]) mem[d_addr[7:2]][8*b +: 8] <= d_wdata[8*b +: 8];
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  typedef struct {
    int          g;
    logic [31:0] data;
    int          stamp;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mmem[MW];
  int          m_ptr, m_owner, cyc;
  bit          m_locked;
  bit          accepted[N];

  // Model: evaluates each cycle mid-period with inputs stable
  initial begin
    int          g;
    exp_t        e;
    logic [5:0]  idx;
    for (int i = 0; i < MW; i++) mmem[i] = init_word(i);
    m_ptr = 0; m_owner = 0; m_locked = 0; cyc = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) accepted[i] = 0;
      if (!rst_n) begin
        m_ptr = 0; m_owner = 0; m_locked = 0;
        q.delete();
        continue;
      end
      cyc++;
      g = -1;
      if (m_locked && v[m_owner]) g = m_owner;
      else
        for (int k = 0; k < N; k++)
          if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      chk("grant", 64'(req_ready), (g < 0) ? 64'h0 : (64'h1 << g));
      if (g < 0) begin
        chk("idle_wstrb", 64'(d_wstrb), 64'h0);
        chk("idle_addr", 64'(d_addr), 64'h0);
        if (m_locked && !v[m_owner]) m_locked = 0;
      end else begin
        chk("d_addr", 64'(d_addr), 64'(a[g]));
        chk("d_wstrb", 64'(d_wstrb), 64'(ws[g]));
        if (ws[g] != 4'h0) chk("d_wdata", 64'(d_wdata), 64'(wd[g]));
        idx     = a[g][7:2];
        e.g     = g;
        e.stamp = cyc;
        e.data  = (ws[g] == 4'h0) ? mmem[idx] : 32'h0;
        for (int b = 0; b < 4; b++)
          if (ws[g][b]) mmem[idx][8*b +: 8] = wd[g][8*b +: 8];
        q.push_back(e);
        m_ptr       = (g + 1) % N;
        m_locked    = lk[g];
        m_owner     = g;
        accepted[g] = 1;
      end
    end
  end

  // Monitor: pops an expectation whenever the DUT presents a response
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #4;
      if (rst_n) begin
        if (rsp_valid != '0) begin
          if (q.size() == 0) chk("rsp_unexpected", 64'(rsp_valid), 64'h0);
          else begin
            e = q.pop_front();
            chk("rsp_valid", 64'(rsp_valid), 64'h1 << e.g);
            chk("rsp_rdata", 64'(rsp_rdata[32*e.g +: 32]), 64'(e.data));
            chk("rsp_cycle", 64'(e.stamp), 64'(cyc));
          end
        end else if (q.size() != 0 && q[0].stamp == cyc) begin
          e = q.pop_front();
          chk("rsp_missing", 64'(rsp_valid), 64'h1 << e.g);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int i, logic val, logic lock, logic [31:0] ad,
                         logic [31:0] dat, logic [3:0] st);
    v[i] = val; lk[i] = lock; a[i] = ad; wd[i] = dat; ws[i] = st;
  endtask

  task automatic idle_all();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic do_reset();
    idle_all();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  logic [31:0] snap[MW];

  initial begin
    int diffs;
    rst_n = 1'b0;
    idle_all();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("reset_rsp_rdata", 64'(rsp_rdata), 64'h0);
    chk("reset_ready", 64'(req_ready), 64'h0);
    chk("reset_wstrb", 64'(d_wstrb), 64'h0);
    rst_n = 1'b1;

    // Single requester write then read back
    set_req(0, 1'b1, 1'b0, 32'h40, 32'hDEADBEEF, 4'hF);
    tick();
    chk("wr_ack_valid", 64'(rsp_valid), 64'h1);
    chk("wr_ack_data", 64'(rsp_rdata[31:0]), 64'h0);
    set_req(0, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
    tick();
    chk("rd_valid", 64'(rsp_valid), 64'h1);
    chk("rd_data", 64'(rsp_rdata[31:0]), 64'hDEADBEEF);
    idle_all();
    tick();

    // Contention from reset: grants alternate 0,1,0,1...
    do_reset();
    set_req(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    set_req(1, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("contend_grant", 64'(req_ready), (k % 2 == 0) ? 64'h1 : 64'h2);
      tick();
    end
    idle_all();
    tick();

    // Byte strobes
    set_req(0, 1'b1, 1'b0, 32'h8, 32'h11223344, 4'hF);
    tick();
    idle_all();
    set_req(1, 1'b1, 1'b0, 32'h8, 32'hAABBCCDD, 4'b0101);
    tick();
    set_req(1, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
    tick();
    chk("strobe_readback", 64'(rsp_rdata[63:32]), 64'h11BB33DD);
    idle_all();
    tick();

    // Lock: req0 keeps grant for 3 accesses, then req1
    set_req(1, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
    for (int k = 0; k < 4; k++) begin
      if (k < 3) set_req(0, 1'b1, (k < 2), 32'h0, 32'h0, 4'h0);
      else       set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      #1;
      chk("lock_grant", 64'(req_ready), (k < 3) ? 64'h1 : 64'h2);
      tick();
    end
    idle_all();
    tick();

    // Idle: memory and port quiet
    for (int i = 0; i < MW; i++) snap[i] = mem[i];
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("idle_rsp_valid", 64'(rsp_valid), 64'h0);
      chk("idle_d_wstrb", 64'(d_wstrb), 64'h0);
    end
    diffs = 0;
    for (int i = 0; i < MW; i++) if (mem[i] !== snap[i]) diffs++;
    chk("idle_mem_unchanged", 64'(diffs), 64'h0);

    // Reset between acceptance and response consumption
    set_req(0, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
    tick();
    idle_all();
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_rsp_valid", 64'(rsp_valid), 64'h0);
    tick();
    rst_n = 1'b1;
    set_req(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    set_req(1, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
    #1;
    chk("rst_mid_grant", 64'(req_ready), 64'h1);
    tick();
    idle_all();
    tick();

    // Random traffic; pending requests stay stable until accepted
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (accepted[i]) v[i] = 1'b0;
        if (!v[i] && $urandom_range(0, 9) < 6)
          set_req(i, 1'b1, ($urandom_range(0, 3) == 0),
                  {26'h0, 4'($urandom_range(0, 15)), 2'b00}, $urandom,
                  ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0);
      end
      tick();
    end
    idle_all();
    repeat (3) tick();

    chk("scoreboard_drained", 64'(q.size()), 64'h0);
    diffs = 0;
    for (int i = 0; i < MW; i++) if (mem[i] !== mmem[i]) diffs++;
    chk("final_mem", 64'(diffs), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-ported data memory between `N_REQ` requesters, for example the core data port and a test/DMA loader, using round-robin arbitration with optional grant locking. It sits between the requesters and the data memory and drives the memory's `d_addr`/`d_wdata`/`d_wstrb` port. The memory returns `d_rdata` combinationally and writes on the rising clock edge. Each accepted access returns a registered one-cycle response to its originator.

## Interface
- `N_REQ`, 2: number of requesters, 2..8.
- `clk`  in  1: sole clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  N_REQ: requester i has an access pending.
- `req_lock`  in  N_REQ: requester i asks to keep the grant after this access.
- `req_addr`  in  N_REQ×32: byte address (word-aligned use; low 2 bits passed through).
- `req_wdata`  in  N_REQ×32: write data.
- `req_wstrb`  in  N_REQ×4: byte enables; 0 means read.
- `req_ready`  out  N_REQ: one-hot grant; access accepted when `req_valid[i] && req_ready[i]` at the clock edge.
- `rsp_valid`  out  N_REQ: response for requester i, one cycle pulse.
- `rsp_rdata`  out  N_REQ×32: read data; 0 for write acks.
- `d_addr`  out  32: to memory.
- `d_wdata`  out  32: to memory.
- `d_wstrb`  out  4: to memory; forced 0 when no grant.
- `d_rdata`  in  32: from memory, combinational from `d_addr`.

## Operation
- **Grant selection (combinational, each cycle):**
  - If `locked` is set and `req_valid[owner]` is high, grant `owner`.
  - Otherwise, grant the first valid requester scanning from `rr_ptr` upward, wrapping modulo `N_REQ`.
  - With no valid requests, grant nothing: `req_ready` = 0, `d_wstrb` = 0, `d_addr`/`d_wdata` = 0.
- **Memory mux:** the granted requester's addr/wdata/wstrb drive `d_*` the same cycle. A write commits at that edge.
- **On acceptance of requester g:**
  - `rr_ptr` ← (g+1) mod `N_REQ`.
  - `locked` ← `req_lock[g]`, `owner` ← g.
  - Response register loads: `rsp_valid` ← onehot(g). `rsp_rdata[g]` ← `d_rdata` for a read (wstrb == 0), else 0.
- **Without acceptance:** `rsp_valid` ← 0, and `rsp_rdata` holds its last value.
- **Lock release:**
  - A locked owner releases by issuing an access with `req_lock` = 0.
  - If the owner drops `req_valid` while locked, `locked` clears at that edge and others are arbitrated normally the next cycle.
- Responses have no backpressure; requesters must accept `rsp_valid` unconditionally.

## Timing
- **Reset (async assert, sync-safe deassert by upstream):**
  - `rsp_valid` = 0, `rsp_rdata` = 0.
  - `rr_ptr` = 0 (requester 0 highest priority), `locked` = 0, `owner` = 0.
- **Throughput:** one access per cycle, back-to-back across requesters.
- **Latency:**
  - Grant in the same cycle as the request.
  - Read data is `rsp_rdata` in the cycle after acceptance.
  - Write is visible in memory to a read issued the next cycle.
- **Simultaneous requests:** exactly one grant per cycle; losers hold `req_valid`, addr, data and strobes stable until accepted.
- **Read-after-write, same cycle:** impossible, because there is one port.
- **Pointer wrap:** granting requester `N_REQ`-1 sets `rr_ptr` to 0.
- **Reset mid-operation:** any in-flight response is dropped, and a write already committed stays in memory.

## Structure
- `dmem_arb_pkg` holds:
  - `MAX_REQ` = 8.
  - Typedef `mem_req_t` {addr[31:0], wdata[31:0], wstrb[3:0]}.
  - Function `rr_pick(valid, ptr)`, returning the one-hot grant.
- One natural sub-module, `rr_arbiter`: `N_REQ` request vector in, one-hot grant out, with the `rr_ptr` register and lock override inside. `dmem_arbiter` keeps the muxing and the response registers.

## Test plan
- **Single reader:** after reset, write 0xDEADBEEF to 0x40 via req0 (wstrb = 0xF), then read 0x40.
  - Required: `rsp_valid[0]` on the cycle after each access, and `rsp_rdata[0]` = 0xDEADBEEF.
- **Contention:** req0 and req1 both valid continuously, reading 0x0 and 0x4.
  - Required: grants alternate 0,1,0,1 from reset, and each `rsp_valid` pulses every other cycle.
- **Byte strobes:** mem[0x8] = 0x11223344, then req1 writes 0xAABBCCDD with wstrb = 0b0101, then reads.
  - Required: readback 0x11BB33DD.
- **Lock:** req0 issues 3 accesses with `req_lock` = 1, 1, 0 while req1 is valid throughout.
  - Required: req0 is granted 3 consecutive cycles, and req1 is granted on the 4th.
- **Idle:** no `req_valid` for 5 cycles.
  - Required: `d_wstrb` = 0 and `rsp_valid` = 0 throughout, and memory is unchanged.
- **Reset mid-read:** assert `rst_n` low between acceptance and the response edge.
  - Required: `rsp_valid` = 0 immediately, and the next contended grant goes to req0.
